clb_bank_config_ctrl: RTL and testbench

Configuration controller for a logic tile's memory-bank configuration port (`bl`/`wl`). It accepts a configuration stream over a valid/ready word interface and assembles one full bit-line frame per word-line row. It then pulses the corresponding word line for a programmable width and sequences through all rows. It sits between the fabric-level configuration loader and the `bl`/`wl` inputs of a `grid_clb` tile.

---
 rtl/clb_bank_config_ctrl.sv | 117 +++++++++++
 tb/tb_clb_bank_config_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clb_bank_config_ctrl.sv
// Memory-bank configuration controller for a grid_clb tile.
// Assembles one bl frame per row from a word stream, then pulses that row's wl.
module clb_bank_config_ctrl #(
    parameter int NUM_BL   = 1020,
    parameter int NUM_WL   = 1,
    parameter int DATA_W   = 32,
    parameter int WL_PULSE = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [0:NUM_BL-1] bl,
    output logic [0:NUM_WL-1] wl,
    output logic              cfg_busy,
    output logic              cfg_done
);

    localparam int WPR = (NUM_BL + DATA_W - 1) / DATA_W;
    localparam int WCW = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int RCW = (NUM_WL > 1) ? $clog2(NUM_WL) : 1;
    localparam int PCW = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;
    localparam logic [WCW-1:0] WORD_LAST  = WCW'(WPR - 1);
    localparam logic [RCW-1:0] ROW_LAST   = RCW'(NUM_WL - 1);
    localparam logic [PCW-1:0] PULSE_LAST = PCW'(WL_PULSE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PULSE, S_GAP, S_DONE
    } state_t;

    state_t           state;
    logic [WCW-1:0]   word_cnt;
    logic [RCW-1:0]   row_cnt;
    logic [PCW-1:0]   pulse_cnt;
    logic [WPR-1:0]   word_hit;
    logic [0:NUM_BL-1] bl_next;
    logic [0:NUM_WL-1] row_hot;

    // Per-bit slice select; bits past NUM_BL-1 in the last word have no target.
    for (genvar k = 0; k < WPR; k++) begin : g_word
        assign word_hit[k] = (word_cnt == WCW'(k));
    end
    for (genvar i = 0; i < NUM_BL; i++) begin : g_bl
        assign bl_next[i] = word_hit[i / DATA_W] ? cfg_data[i % DATA_W] : bl[i];
    end
    for (genvar r = 0; r < NUM_WL; r++) begin : g_row
        assign row_hot[r] = (row_cnt == RCW'(r));
    end

    assign cfg_ready = (state == S_LOAD);
    assign cfg_busy  = (state != S_IDLE);
    assign cfg_done  = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            word_cnt  <= '0;
            row_cnt   <= '0;
            pulse_cnt <= '0;
            bl        <= '0;
            wl        <= '0;
        end else if (cfg_abort && state != S_IDLE) begin
            // Abort wins over any accept this cycle; bl keeps what it has.
            state <= S_IDLE;
            wl    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_start && !cfg_abort) begin
                        state    <= S_LOAD;
                        word_cnt <= '0;
                        row_cnt  <= '0;
                    end
                end
                S_LOAD: begin
                    if (cfg_valid) begin
                        bl <= bl_next;
                        if (word_cnt == WORD_LAST) begin
                            word_cnt  <= '0;
                            pulse_cnt <= '0;
                            wl        <= row_hot;
                            state     <= S_PULSE;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                S_PULSE: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        wl    <= '0;
                        state <= S_GAP;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (row_cnt == ROW_LAST) begin
                        state <= S_DONE;
                    end else begin
                        row_cnt  <= row_cnt + 1'b1;
                        word_cnt <= '0;
                        state    <= S_LOAD;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: begin
                    state <= S_IDLE;
                    wl    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clb_bank_config_ctrl.sv
// Directed bench for clb_bank_config_ctrl: default instance plus a 3-row,
// 1-cycle-pulse instance driven with random valid bubbles.
module tb_clb_bank_config_ctrl;

    localparam int NBL = 1020;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            start, abort, valid;
    logic [31:0]     data;
    logic            ready, busy, done;
    logic [0:NBL-1]  bl;
    logic [0:0]      wl;

    logic            start3, abort3, valid3;
    logic [15:0]     data3;
    logic            ready3, busy3, done3;
    logic [0:39]     bl3;
    logic [0:2]      wl3;

    clb_bank_config_ctrl dut (
        .clk(clk), .reset(reset), .cfg_start(start), .cfg_abort(abort),
        .cfg_data(data), .cfg_valid(valid), .cfg_ready(ready), .bl(bl),
        .wl(wl), .cfg_busy(busy), .cfg_done(done)
    );

    clb_bank_config_ctrl #(.NUM_BL(40), .NUM_WL(3), .DATA_W(16), .WL_PULSE(1)) dut3 (
        .clk(clk), .reset(reset), .cfg_start(start3), .cfg_abort(abort3),
        .cfg_data(data3), .cfg_valid(valid3), .cfg_ready(ready3), .bl(bl3),
        .wl(wl3), .cfg_busy(busy3), .cfg_done(done3)
    );

    int             n_assert = 0;
    int             n_fail = 0;
    logic [0:NBL-1] exp_bl, prev_bl;
    logic [0:39]    exp_bl3, prev_bl3;
    logic [0:0]     prev_wl;
    logic [0:2]     prev_wl3;
    logic [0:2]     wl_q[$];
    int             done3_cnt = 0;
    logic [31:0]    words[32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_bl(input string tag);
        int first;
        first = -1;
        n_assert++;
        assert (bl === exp_bl) else begin
            n_fail++;
            for (int i = 0; i < NBL; i++)
                if (first < 0 && bl[i] !== exp_bl[i]) first = i;
            $error("FAIL %s bl bit %0d observed=%b expected=%b", tag, first, bl[first], exp_bl[first]);
        end
    endtask

    // One clock; then monitor both instances at the falling edge.
    task automatic step();
        logic [0:2] e;
        @(posedge clk);
        @(negedge clk);
        if (prev_wl !== '0) begin
            n_assert++;
            assert (bl === prev_bl) else begin
                n_fail++;
                $error("FAIL bl_stable_dflt observed=changed expected=held");
            end
        end
        if (prev_wl3 !== '0) chk("bl3_stable", 64'(bl3), 64'(prev_bl3));
        if (wl3 !== prev_wl3) begin
            n_assert++;
            assert (wl_q.size() > 0) else begin
                n_fail++;
                $error("FAIL wl3_unexpected observed=%b expected=none", wl3);
            end
            if (wl_q.size() > 0) begin
                e = wl_q.pop_front();
                chk("wl3_seq", 64'(wl3), 64'(e));
            end
        end
        if (done3 === 1'b1) done3_cnt++;
        prev_wl  = wl;
        prev_wl3 = wl3;
        prev_bl  = bl;
        prev_bl3 = bl3;
    endtask

    // Full pass on the default instance with cycle-exact expectations.
    task automatic pass_dflt(input string name, input int abort_at, input int start_at, input int reset_at);
        bit stopped;
        int widx, idx;
        stopped = 0;
        start = 1'b1; valid = 1'b0; abort = 1'b0;
        step();
        start = 1'b0;
        chk({name, "_busy1"}, 64'(busy), 64'(1));
        chk({name, "_ready1"}, 64'(ready), 64'(1));
        for (int c = 1; c <= 40; c++) begin
            widx  = c - 1;
            valid = (widx < 32);
            data  = (widx < 32) ? words[widx] : 32'hDEAD_BEEF;
            abort = (c == abort_at);
            start = (c == start_at);
            reset = (c != reset_at);
            if (c == reset_at) begin
                exp_bl  = '0;
                stopped = 1;
            end else if (c == abort_at) begin
                stopped = 1;
            end else if (!stopped && widx < 32) begin
                for (int j = 0; j < 32; j++) begin
                    idx = widx * 32 + j;
                    if (idx < NBL) exp_bl[idx] = words[widx][j];
                end
            end
            step();
            abort = 1'b0; start = 1'b0; reset = 1'b1;
            chk({name, "_wl"},    64'(wl),    64'(!stopped && c + 1 >= 33 && c + 1 <= 34));
            chk({name, "_done"},  64'(done),  64'(!stopped && c + 1 == 36));
            chk({name, "_busy"},  64'(busy),  64'(!stopped && c + 1 <= 36));
            chk({name, "_ready"}, 64'(ready), 64'(!stopped && c + 1 <= 32));
            chk_bl(name);
        end
        valid = 1'b0;
    endtask

    initial begin
        int m_state, m_w, m_r, idx;
        bit v;
        logic [15:0] d;
        logic [0:2]  oh;

        reset = 1'b0; start = 0; abort = 0; valid = 0; data = '0;
        start3 = 0; abort3 = 0; valid3 = 0; data3 = '0;
        exp_bl = '0; exp_bl3 = '0; prev_wl = '0; prev_wl3 = '0;
        prev_bl = '0; prev_bl3 = '0;
        step();
        step();
        chk_bl("rst_bl");
        chk("rst_wl", 64'(wl), 64'(0));
        chk("rst_ready", 64'(ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_bl3", 64'(bl3), 64'(exp_bl3));
        reset = 1'b1;
        step();

        // Incrementing words.
        for (int k = 0; k < 32; k++) words[k] = 32'(k + 1);
        pass_dflt("inc", 0, 0, 0);
        chk("inc_bl0", 64'(bl[0]), 64'(1));
        chk("inc_bl32", 64'(bl[32]), 64'(0));
        chk("inc_bl33", 64'(bl[33]), 64'(1));

        // Last-word truncation.
        for (int k = 0; k < 32; k++) words[k] = '0;
        words[31] = 32'hFFFF_FFFF;
        pass_dflt("trunc", 0, 0, 0);
        chk("trunc_hi", 64'(bl[992:1019]), 64'h0FFF_FFFF);
        chk("trunc_991", 64'(bl[991]), 64'(0));

        // start together with abort in IDLE stays idle.
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 64'(busy), 64'(0));

        for (int k = 0; k < 32; k++) words[k] = $urandom;
        pass_dflt("abort_pulse", 34, 0, 0);
        for (int k = 0; k < 32; k++) words[k] = $urandom;
        pass_dflt("abort_load", 6, 0, 0);
        for (int k = 0; k < 32; k++) words[k] = $urandom;
        pass_dflt("start_mid", 0, 10, 0);

        // Three rows, single-cycle pulse, random bubbles.
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        m_state = 1; m_w = 0; m_r = 0;
        chk("dut3_busy_start", 64'(busy3), 64'(1));
        for (int cyc = 0; cyc < 300 && m_state != 0; cyc++) begin
            v = ($urandom_range(0, 3) != 0);
            d = 16'($urandom);
            valid3 = v;
            data3  = d;
            case (m_state)
                1: if (v) begin
                    for (int j = 0; j < 16; j++) begin
                        idx = m_w * 16 + j;
                        if (idx < 40) exp_bl3[idx] = d[j];
                    end
                    if (m_w == 2) begin
                        oh = '0;
                        oh[m_r] = 1'b1;
                        wl_q.push_back(oh);
                        wl_q.push_back(3'b000);
                        m_w = 0;
                        m_state = 2;
                    end else begin
                        m_w++;
                    end
                end
                2: m_state = 3;
                3: if (m_r == 2) m_state = 4;
                   else begin
                       m_r++;
                       m_state = 1;
                   end
                4: m_state = 0;
                default: m_state = 0;
            endcase
            step();
            chk("dut3_ready", 64'(ready3), 64'(m_state == 1));
            chk("dut3_busy",  64'(busy3),  64'(m_state != 0));
            chk("dut3_done",  64'(done3),  64'(m_state == 4));
            chk("dut3_bl",    64'(bl3),    64'(exp_bl3));
        end
        valid3 = 1'b0;
        step();
        chk("dut3_wl_queue_empty", 64'(wl_q.size()), 64'(0));
        chk("dut3_done_count", 64'(done3_cnt), 64'(1));

        // Reset mid-LOAD, then a clean pass afterwards.
        for (int k = 0; k < 32; k++) words[k] = $urandom;
        pass_dflt("reset_mid", 0, 0, 10);
        exp_bl3 = '0;
        chk("reset_bl3", 64'(bl3), 64'(exp_bl3));
        for (int k = 0; k < 32; k++) words[k] = $urandom;
        pass_dflt("after_reset", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
